// File: rtl/trap_pkg.sv
// Shared definitions for the machine-mode trap/CSR unit: CSR addresses,
// interrupt cause codes, FSM states and CSR operation encodings.
package trap_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;

    localparam logic [31:0] MCAUSE_EXT   = 32'h8000_000B;
    localparam logic [31:0] MCAUSE_SW    = 32'h8000_0003;
    localparam logic [31:0] MCAUSE_TIMER = 32'h8000_0007;

    localparam int unsigned MSTATUS_MIE  = 3;
    localparam int unsigned MSTATUS_MPIE = 7;

    typedef enum logic {
        ST_RUN,
        ST_FLUSH
    } state_t;

    // csr_fun3[2] selects the immediate operand form only; the op lives in [1:0]
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_RW   = 2'b01,
        OP_RS   = 2'b10,
        OP_RC   = 2'b11
    } csr_op_t;

    function automatic logic [31:0] csr_apply(input csr_op_t op,
                                              input logic [31:0] old,
                                              input logic [31:0] wdata);
        logic [31:0] res;
        res = old;
        case (op)
            OP_RW:   res = wdata;
            OP_RS:   res = old | wdata;
            OP_RC:   res = old & ~wdata;
            default: res = old;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/trap_csr_unit_csr_file.sv
// Machine-mode CSR storage and combinational read mux, with trap entry and
// MRET side effects on mstatus/mepc/mcause.
module csr_file
    import trap_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
    parameter logic [31:0] HARTID      = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] addr,
    input  logic        wr_en,
    input  logic [1:0]  op,
    input  logic [31:0] wdata,
    input  logic        trap_commit,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_cause,
    input  logic        mret_commit,
    input  logic        irq_ext,
    input  logic        irq_sw,
    input  logic        irq_timer,
    output logic [31:0] rdata,
    output logic        mstatus_mie,
    output logic [31:0] mie,
    output logic [31:0] mip,
    output logic [31:0] mtvec,
    output logic [31:0] mepc
);

    logic        mie_bit;
    logic        mpie_bit;
    logic [31:0] mie_q;
    logic [31:0] mtvec_q;
    logic [31:0] mepc_q;
    logic [31:0] mcause_q;
    logic [31:0] mscratch_q;
    logic [31:0] mstatus_w;
    logic [31:0] wval;

    assign mip       = {20'b0, irq_ext, 3'b0, irq_timer, 3'b0, irq_sw, 3'b0};
    assign mstatus_w = {24'b0, mpie_bit, 3'b0, mie_bit, 3'b0};

    assign mstatus_mie = mie_bit;
    assign mie         = mie_q;
    assign mtvec       = mtvec_q;
    assign mepc        = mepc_q;

    always_comb begin
        rdata = '0;
        case (addr)
            CSR_MSTATUS:  rdata = mstatus_w;
            CSR_MIE:      rdata = mie_q;
            CSR_MIP:      rdata = mip;
            CSR_MTVEC:    rdata = mtvec_q;
            CSR_MEPC:     rdata = mepc_q;
            CSR_MCAUSE:   rdata = mcause_q;
            CSR_MSCRATCH: rdata = mscratch_q;
            CSR_MHARTID:  rdata = HARTID;
            default:      rdata = '0;
        endcase
    end

    assign wval = csr_apply(csr_op_t'(op), rdata, wdata);

    always_ff @(posedge clk) begin
        if (reset) begin
            mie_bit    <= 1'b0;
            mpie_bit   <= 1'b0;
            mie_q      <= '0;
            mtvec_q    <= MTVEC_RESET;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mscratch_q <= '0;
        end else if (trap_commit) begin
            mepc_q   <= trap_pc;
            mcause_q <= trap_cause;
            mpie_bit <= mie_bit;
            mie_bit  <= 1'b0;
        end else if (mret_commit) begin
            mie_bit  <= mpie_bit;
            mpie_bit <= 1'b1;
        end else if (wr_en) begin
            case (addr)
                CSR_MSTATUS: begin
                    mie_bit  <= wval[MSTATUS_MIE];
                    mpie_bit <= wval[MSTATUS_MPIE];
                end
                CSR_MIE:      mie_q      <= wval;
                CSR_MTVEC:    mtvec_q    <= wval;
                CSR_MEPC:     mepc_q     <= wval;
                CSR_MCAUSE:   mcause_q   <= wval;
                CSR_MSCRATCH: mscratch_q <= wval;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/trap_csr_unit.sv
// MEM-stage interrupt/MRET controller: picks the highest-priority enabled
// interrupt, redirects fetch and sequences a one-cycle flush after each redirect.
module trap_csr_unit
    import trap_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
    parameter logic [31:0] HARTID      = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic [31:0] pc_mem,
    input  logic        is_csr_instr,
    input  logic        csr_write,
    input  logic [2:0]  csr_fun3,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    input  logic        is_mret_instr,
    input  logic        stall_pipl,
    input  logic        irq_ext,
    input  logic        irq_sw,
    input  logic        irq_timer,
    output logic [31:0] csr_rdata,
    output logic        trap_taken,
    output logic        mret_exec,
    output logic [31:0] redirect_pc
);

    state_t      state;
    logic        mstatus_mie;
    logic [31:0] mie;
    logic [31:0] mip;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic [31:0] irq_act;
    logic        pending;
    logic [31:0] cause;
    logic        csr_wr_en;
    logic        in_run;
    logic        unused_imm;

    assign unused_imm = csr_fun3[2];

    assign irq_act = mie & mip;
    assign pending = mstatus_mie & (|irq_act);
    assign in_run  = (state == ST_RUN) & ~reset;

    always_comb begin
        cause = MCAUSE_TIMER;
        if (irq_act[11])
            cause = MCAUSE_EXT;
        else if (irq_act[3])
            cause = MCAUSE_SW;
    end

    // Redirects are combinational so fetch can turn around in the trap cycle;
    // MRET outranks an interrupt that becomes pending in the same cycle.
    always_comb begin
        mret_exec   = in_run & is_mret_instr & mem_valid & ~stall_pipl;
        trap_taken  = in_run & pending & mem_valid & ~stall_pipl & ~is_mret_instr;
        redirect_pc = '0;
        if (trap_taken)
            redirect_pc = {mtvec[31:2], 2'b00};
        else if (mret_exec)
            redirect_pc = mepc;
    end

    assign csr_wr_en = is_csr_instr & csr_write & mem_valid & ~stall_pipl & ~trap_taken;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RUN;
        end else if (!stall_pipl) begin
            case (state)
                ST_RUN:   if (trap_taken || mret_exec) state <= ST_FLUSH;
                ST_FLUSH: state <= ST_RUN;
                default:  state <= ST_RUN;
            endcase
        end
    end

    csr_file #(
        .MTVEC_RESET(MTVEC_RESET),
        .HARTID     (HARTID)
    ) u_csr_file (
        .clk        (clk),
        .reset      (reset),
        .addr       (csr_addr),
        .wr_en      (csr_wr_en),
        .op         (csr_fun3[1:0]),
        .wdata      (csr_wdata),
        .trap_commit(trap_taken),
        .trap_pc    (pc_mem),
        .trap_cause (cause),
        .mret_commit(mret_exec),
        .irq_ext    (irq_ext),
        .irq_sw     (irq_sw),
        .irq_timer  (irq_timer),
        .rdata      (csr_rdata),
        .mstatus_mie(mstatus_mie),
        .mie        (mie),
        .mip        (mip),
        .mtvec      (mtvec),
        .mepc       (mepc)
    );

endmodule

// File: tb/tb_trap_csr_unit.sv
// Directed self-checking bench for trap_csr_unit: CSR ops, interrupt entry,
// MRET, priority, stall freezing, write suppression and reset behaviour.
module tb_trap_csr_unit;

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MHARTID  = 12'hF14;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid;
    logic [31:0] pc_mem;
    logic        is_csr_instr;
    logic        csr_write;
    logic [2:0]  csr_fun3;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        is_mret_instr;
    logic        stall_pipl;
    logic        irq_ext, irq_sw, irq_timer;
    logic [31:0] csr_rdata;
    logic        trap_taken;
    logic        mret_exec;
    logic [31:0] redirect_pc;

    int total = 0;
    int bad   = 0;

    trap_csr_unit #(
        .MTVEC_RESET(32'h0000_0100),
        .HARTID     (32'd0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_valid    (mem_valid),
        .pc_mem       (pc_mem),
        .is_csr_instr (is_csr_instr),
        .csr_write    (csr_write),
        .csr_fun3     (csr_fun3),
        .csr_addr     (csr_addr),
        .csr_wdata    (csr_wdata),
        .is_mret_instr(is_mret_instr),
        .stall_pipl   (stall_pipl),
        .irq_ext      (irq_ext),
        .irq_sw       (irq_sw),
        .irq_timer    (irq_timer),
        .csr_rdata    (csr_rdata),
        .trap_taken   (trap_taken),
        .mret_exec    (mret_exec),
        .redirect_pc  (redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_valid     = 1'b0;
        is_csr_instr  = 1'b0;
        csr_write     = 1'b0;
        is_mret_instr = 1'b0;
    endtask

    task automatic peek(input logic [11:0] a, output logic [31:0] v);
        idle();
        csr_addr = a;
        #1;
        v = csr_rdata;
    endtask

    task automatic csr_op(input logic [2:0] f, input logic [11:0] a,
                          input logic [31:0] d, input logic [31:0] old);
        mem_valid = 1'b1; is_csr_instr = 1'b1; csr_write = 1'b1;
        csr_fun3 = f; csr_addr = a; csr_wdata = d;
        #1;
        total++;
        if (csr_rdata !== old) begin
            bad++;
            $display("FAIL csr_op_old addr=%h got=%h exp=%h", a, csr_rdata, old);
        end
        step();
        idle();
    endtask

    task automatic do_mret();
        is_mret_instr = 1'b1; mem_valid = 1'b1;
        #1;
        total++;
        if (mret_exec !== 1'b1 || trap_taken !== 1'b0) begin
            bad++;
            $display("FAIL do_mret got mret=%b trap=%b exp mret=1 trap=0", mret_exec, trap_taken);
        end
        step();
        idle();
        step();
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset = 1'b1; idle(); stall_pipl = 1'b0;
        irq_ext = 1'b0; irq_sw = 1'b0; irq_timer = 1'b0;
        pc_mem = '0; csr_fun3 = '0; csr_addr = '0; csr_wdata = '0;
        step(); step();
        mem_valid = 1'b1; is_mret_instr = 1'b1;
        #1;
        total++;
        if (trap_taken !== 1'b0 || mret_exec !== 1'b0 || redirect_pc !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs got trap=%b mret=%b pc=%h exp 0/0/0", trap_taken, mret_exec, redirect_pc);
        end
        peek(A_MTVEC, v);
        total++; if (v !== 32'h100) begin bad++; $display("FAIL reset_mtvec got=%h exp=00000100", v); end
        peek(A_MSTATUS, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL reset_mstatus got=%h exp=0", v); end
        peek(A_MHARTID, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL reset_mhartid got=%h exp=0", v); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_csr_ops();
        logic [31:0] v;
        csr_op(3'b001, A_MSCRATCH, 32'h0000_F0F0, 32'h0);
        csr_op(3'b010, A_MSCRATCH, 32'h0000_0F00, 32'h0000_F0F0);
        csr_op(3'b011, A_MSCRATCH, 32'h0000_00F0, 32'h0000_FFF0);
        csr_op(3'b101, A_MSCRATCH, 32'h0000_001F, 32'h0000_FF00);
        peek(A_MSCRATCH, v);
        total++; if (v !== 32'h1F) begin bad++; $display("FAIL csr_imm_rw got=%h exp=0000001f", v); end
        csr_op(3'b001, A_MIP, 32'hFFFF_FFFF, 32'h0);
        csr_op(3'b001, A_MHARTID, 32'h1234_5678, 32'h0);
        peek(A_MIP, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL mip_readonly got=%h exp=0", v); end
        peek(A_MHARTID, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL mhartid_readonly got=%h exp=0", v); end
        step();
    endtask

    task automatic test_irq_trap();
        logic [31:0] v;
        csr_op(3'b010, A_MSTATUS, 32'h8, 32'h0);
        csr_op(3'b001, A_MIE, 32'h800, 32'h0);
        irq_ext = 1'b1;
        peek(A_MIP, v);
        total++; if (v !== 32'h800) begin bad++; $display("FAIL mip_ext got=%h exp=00000800", v); end
        total++; if (trap_taken !== 1'b0) begin bad++; $display("FAIL trap_needs_valid got=%b exp=0", trap_taken); end
        pc_mem = 32'h40; mem_valid = 1'b1;
        #1;
        total++;
        if (trap_taken !== 1'b1 || mret_exec !== 1'b0 || redirect_pc !== 32'h100) begin
            bad++;
            $display("FAIL trap_entry got trap=%b mret=%b pc=%h exp 1/0/00000100", trap_taken, mret_exec, redirect_pc);
        end
        step();
        #1;
        total++;
        if (trap_taken !== 1'b0 || mret_exec !== 1'b0) begin
            bad++;
            $display("FAIL trap_one_cycle got trap=%b mret=%b exp 0/0", trap_taken, mret_exec);
        end
        idle();
        step();
        peek(A_MEPC, v);
        total++; if (v !== 32'h40) begin bad++; $display("FAIL trap_mepc got=%h exp=00000040", v); end
        peek(A_MCAUSE, v);
        total++; if (v !== 32'h8000_000B) begin bad++; $display("FAIL trap_mcause got=%h exp=8000000b", v); end
        peek(A_MSTATUS, v);
        total++; if (v !== 32'h80) begin bad++; $display("FAIL trap_mstatus got=%h exp=00000080", v); end
        step();
    endtask

    task automatic test_mret_retrap();
        logic [31:0] v;
        is_mret_instr = 1'b1; mem_valid = 1'b1;
        #1;
        total++;
        if (mret_exec !== 1'b1 || trap_taken !== 1'b0 || redirect_pc !== 32'h40) begin
            bad++;
            $display("FAIL mret_exec got mret=%b trap=%b pc=%h exp 1/0/00000040", mret_exec, trap_taken, redirect_pc);
        end
        step();
        is_mret_instr = 1'b0; pc_mem = 32'h44; csr_addr = A_MSTATUS;
        #1;
        total++;
        if (mret_exec !== 1'b0 || trap_taken !== 1'b0 || csr_rdata !== 32'h88) begin
            bad++;
            $display("FAIL mret_flush got mret=%b trap=%b mstatus=%h exp 0/0/00000088", mret_exec, trap_taken, csr_rdata);
        end
        step();
        total++;
        if (trap_taken !== 1'b1 || redirect_pc !== 32'h100) begin
            bad++;
            $display("FAIL retrap got trap=%b pc=%h exp 1/00000100", trap_taken, redirect_pc);
        end
        step();
        idle();
        step();
        peek(A_MEPC, v);
        total++; if (v !== 32'h44) begin bad++; $display("FAIL retrap_mepc got=%h exp=00000044", v); end
        step();
    endtask

    task automatic test_priority();
        logic [31:0] v;
        irq_ext = 1'b0;
        step();
        do_mret();
        csr_op(3'b001, A_MIE, 32'h888, 32'h800);
        irq_ext = 1'b1; irq_timer = 1'b1; pc_mem = 32'h80; mem_valid = 1'b1;
        #1;
        total++; if (trap_taken !== 1'b1) begin bad++; $display("FAIL prio_ext_trap got=%b exp=1", trap_taken); end
        step(); idle(); step();
        peek(A_MCAUSE, v);
        total++; if (v !== 32'h8000_000B) begin bad++; $display("FAIL prio_ext_timer got=%h exp=8000000b", v); end
        irq_ext = 1'b0; irq_timer = 1'b0;
        step();
        do_mret();
        irq_sw = 1'b1; irq_timer = 1'b1; mem_valid = 1'b1;
        #1;
        total++; if (trap_taken !== 1'b1) begin bad++; $display("FAIL prio_sw_trap got=%b exp=1", trap_taken); end
        step(); idle(); step();
        peek(A_MCAUSE, v);
        total++; if (v !== 32'h8000_0003) begin bad++; $display("FAIL prio_sw_timer got=%h exp=80000003", v); end
        irq_sw = 1'b0; irq_timer = 1'b0;
        step();
    endtask

    task automatic test_mret_coincide();
        logic [31:0] v;
        do_mret();
        irq_timer = 1'b1; is_mret_instr = 1'b1; mem_valid = 1'b1;
        #1;
        total++;
        if (mret_exec !== 1'b1 || trap_taken !== 1'b0) begin
            bad++;
            $display("FAIL coincide_mret got mret=%b trap=%b exp 1/0", mret_exec, trap_taken);
        end
        step();
        is_mret_instr = 1'b0;
        #1;
        total++;
        if (mret_exec !== 1'b0 || trap_taken !== 1'b0) begin
            bad++;
            $display("FAIL coincide_flush got mret=%b trap=%b exp 0/0", mret_exec, trap_taken);
        end
        step();
        total++;
        if (trap_taken !== 1'b1 || redirect_pc !== 32'h100) begin
            bad++;
            $display("FAIL coincide_late_trap got trap=%b pc=%h exp 1/00000100", trap_taken, redirect_pc);
        end
        step(); idle(); step();
        peek(A_MCAUSE, v);
        total++; if (v !== 32'h8000_0007) begin bad++; $display("FAIL coincide_mcause got=%h exp=80000007", v); end
        irq_timer = 1'b0;
        step();
    endtask

    task automatic test_stall();
        logic [31:0] v;
        do_mret();
        irq_ext = 1'b1; stall_pipl = 1'b1; mem_valid = 1'b1; pc_mem = 32'hC0;
        is_csr_instr = 1'b1; csr_write = 1'b1; csr_fun3 = 3'b001;
        csr_addr = A_MSCRATCH; csr_wdata = 32'h1234;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (trap_taken !== 1'b0 || mret_exec !== 1'b0 || csr_rdata !== 32'h1F) begin
                bad++;
                $display("FAIL stall_frozen cyc=%0d got trap=%b mret=%b mscratch=%h exp 0/0/0000001f", i, trap_taken, mret_exec, csr_rdata);
            end
            step();
        end
        stall_pipl = 1'b0;
        #1;
        total++;
        if (trap_taken !== 1'b1) begin bad++; $display("FAIL stall_release_trap got=%b exp=1", trap_taken); end
        step(); idle(); step();
        peek(A_MSCRATCH, v);
        total++; if (v !== 32'h1F) begin bad++; $display("FAIL stall_mscratch got=%h exp=0000001f", v); end
        peek(A_MEPC, v);
        total++; if (v !== 32'hC0) begin bad++; $display("FAIL stall_mepc got=%h exp=000000c0", v); end
        irq_ext = 1'b0;
        step();
    endtask

    task automatic test_trap_suppress();
        logic [31:0] v;
        do_mret();
        csr_op(3'b001, A_MSCRATCH, 32'h5555, 32'h1F);
        irq_ext = 1'b1; pc_mem = 32'h100;
        mem_valid = 1'b1; is_csr_instr = 1'b1; csr_write = 1'b1; csr_fun3 = 3'b001;
        csr_addr = A_MSCRATCH; csr_wdata = 32'hDEAD_BEEF;
        #1;
        total++; if (trap_taken !== 1'b1) begin bad++; $display("FAIL suppress_trap got=%b exp=1", trap_taken); end
        step(); idle(); step();
        peek(A_MSCRATCH, v);
        total++; if (v !== 32'h5555) begin bad++; $display("FAIL suppress_mscratch got=%h exp=00005555", v); end
        irq_ext = 1'b0;
        step();
        csr_op(3'b001, 12'h7C0, 32'h1234, 32'h0);
        peek(12'h7C0, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL unimpl_read got=%h exp=0", v); end
        step();
    endtask

    task automatic test_reset_in_flush();
        is_mret_instr = 1'b1; mem_valid = 1'b1;
        #1;
        total++; if (mret_exec !== 1'b1) begin bad++; $display("FAIL rst_flush_mret got=%b exp=1", mret_exec); end
        step();
        reset = 1'b1;
        #1;
        total++;
        if (mret_exec !== 1'b0 || trap_taken !== 1'b0 || redirect_pc !== 32'h0) begin
            bad++;
            $display("FAIL rst_flush_quiet got mret=%b trap=%b pc=%h exp 0/0/0", mret_exec, trap_taken, redirect_pc);
        end
        step();
        reset = 1'b0;
        #1;
        total++;
        if (mret_exec !== 1'b1 || redirect_pc !== 32'h0) begin
            bad++;
            $display("FAIL rst_flush_run got mret=%b pc=%h exp 1/0", mret_exec, redirect_pc);
        end
        step(); idle(); step();
    endtask

    initial begin
        test_reset();
        test_csr_ops();
        test_irq_trap();
        test_mret_retrap();
        test_priority();
        test_mret_coincide();
        test_stall();
        test_trap_suppress();
        test_reset_in_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/trap_csr_unit.md
TRAP_CSR_UNIT -- requirements
Module: trap_csr_unit

Interface
REQ-001 The block SHALL have parameter MTVEC_RESET, default 32'h0000_0100, meaning the reset value of mtvec (direct mode only).
REQ-002 The block SHALL have parameter HARTID, default 0, meaning the value returned by read-only CSR mhartid.
REQ-003 The block SHALL have these ports, as name, direction, width, meaning:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_valid  in  1  MEM stage holds a real (non-bubble) instruction.
- pc_mem  in  32  PC of the MEM-stage instruction.
- is_csr_instr  in  1  MEM instruction is a CSR op.
- csr_write  in  1  CSR op writes its CSR.
- csr_fun3  in  3  001 CSRRW, 010 CSRRS, 011 CSRRC, 1xx = immediate forms of the same op.
- csr_addr  in  12  target CSR.
- csr_wdata  in  32  rs1 value or zero-extended uimm.
- is_mret_instr  in  1  MEM instruction is MRET.
- stall_pipl  in  1  pipeline frozen.
- irq_ext, irq_sw, irq_timer  in  1 each  level interrupt requests.
- csr_rdata  out  32  old CSR value for rd writeback.
- trap_taken  out  1  one-cycle pulse: flush the pipeline, redirect fetch.
- mret_exec  out  1  one-cycle pulse: redirect fetch to mepc.
- redirect_pc  out  32  fetch target, valid while trap_taken or mret_exec is high.

Function
REQ-004 The block SHALL implement mstatus (MIE bit 3, MPIE bit 7, other bits read 0), mie, mip (read-only, sampled irq lines at bits 11/3/7), mtvec, mepc, mcause, mscratch and mhartid.
REQ-005 csr_rdata SHALL be combinational from csr_addr; unimplemented addresses SHALL read 0 and ignore writes.
REQ-006 A CSR write SHALL commit at the clock edge when is_csr_instr & csr_write & mem_valid & ~stall_pipl & ~trap_taken: RW = wdata; RS = old|wdata; RC = old&~wdata.
REQ-007 The FSM SHALL have states RUN, FLUSH.
REQ-008 In RUN, an interrupt SHALL be pending when mstatus.MIE & (mie & mip) != 0, using pre-write CSR values.
REQ-009 If an interrupt is pending in RUN with mem_valid & ~stall_pipl & ~is_mret_instr, the block SHALL take the trap.
REQ-010 Taking the trap SHALL, in the same cycle, assert trap_taken with redirect_pc = {mtvec[31:2], 2'b00}.
REQ-011 At the edge ending that cycle it SHALL set mepc = pc_mem, MPIE = MIE and MIE = 0, and go to FLUSH.
REQ-012 Interrupt priority SHALL be ext (mcause 32'h8000_000B) > sw (32'h8000_0003) > timer (32'h8000_0007).
REQ-013 A trap SHALL suppress the CSR write of the MEM instruction; that instruction re-executes after MRET.
REQ-014 FLUSH SHALL last exactly one cycle with trap_taken and mret_exec low, then return to RUN.
REQ-015 In RUN, is_mret_instr & mem_valid & ~stall_pipl SHALL assert mret_exec with redirect_pc = mepc.
REQ-016 At the following edge MRET SHALL set MIE = MPIE and MPIE = 1, then go to FLUSH.
REQ-017 When MRET and a pending interrupt coincide, MRET SHALL win; the interrupt is re-evaluated in RUN after FLUSH.
REQ-018 While stall_pipl is high, no CSR, FSM or trap state SHALL change and both pulses SHALL stay low.
REQ-019 trap_taken and mret_exec SHALL never be high in the same cycle.

Reset
REQ-020 On reset the block SHALL set state = RUN and mstatus, mie, mepc, mcause, mscratch = 0, with mtvec = MTVEC_RESET.
REQ-021 On reset the block SHALL drive trap_taken = 0, mret_exec = 0 and redirect_pc = 0.
REQ-022 Reset asserted in FLUSH SHALL return the block to RUN with no pulse emitted.

Structure
REQ-023 A shared package trap_pkg SHALL hold the CSR address constants, the mcause codes, the FSM state enum and the csr_fun3 encodings.
REQ-024 The CSR storage and read mux SHALL be one sub-module, csr_file; FSM and priority logic SHALL stay in trap_csr_unit.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- CSRRS mstatus wdata 8, then CSRRW mie wdata 32'h800, then irq_ext=1 with pc_mem 32'h40 -> trap_taken one cycle, redirect_pc 32'h100, mepc 32'h40, mcause 32'h8000_000B, MIE 0, MPIE 1.
- After the trap, MRET -> mret_exec one cycle, redirect_pc 32'h40, MIE 1; with irq_ext still high, a new trap follows after one FLUSH cycle.
- irq_ext and irq_timer both high, all enabled -> mcause 32'h8000_000B.
- MRET and pending interrupt in the same cycle -> only mret_exec; trap_taken two cycles later.
- Pending interrupt with stall_pipl=1 for 3 cycles -> no pulse and no CSR change; trap fires in the first unstalled cycle.
- CSRRW mscratch 32'hDEAD_BEEF in the trap cycle -> mscratch unchanged; a read of unimplemented 12'h7C0 returns 0.
